// File: rtl/sodor_dmem_sram_bridge.sv
// Data-memory bridge between the 1-stage Sodor core dmem port and a word-wide
// synchronous SRAM with byte enables. Each access is accepted in IDLE and
// answered in the following ACK cycle; faulted accesses never touch the SRAM.
module sodor_dmem_sram_bridge #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned IDX_W       = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_dmem_req_valid,
    input  logic [31:0]      io_dmem_req_bits_addr,
    input  logic [31:0]      io_dmem_req_bits_data,
    input  logic             io_dmem_req_bits_fcn,
    input  logic [2:0]       io_dmem_req_bits_typ,
    output logic             io_dmem_resp_valid,
    output logic [31:0]      io_dmem_resp_bits_data,
    output logic             sram_en,
    output logic             sram_we,
    output logic [3:0]       sram_be,
    output logic [IDX_W-1:0] sram_addr,
    output logic [31:0]      sram_wdata,
    input  logic [31:0]      sram_rdata,
    output logic             fault_valid,
    output logic [15:0]      fault_count
);

    localparam logic [2:0]  MT_B  = 3'd1;
    localparam logic [2:0]  MT_H  = 3'd2;
    localparam logic [2:0]  MT_BU = 3'd5;
    localparam logic [2:0]  MT_HU = 3'd6;
    localparam logic [15:0] FAULT_SAT = 16'hFFFF;

    typedef enum logic {
        IDLE,
        ACK
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [1:0]  addr_lo_q;
    logic [2:0]  typ_q;
    logic        fcn_q;
    logic        fault_q;

    logic [29:0] word_off;
    logic        is_byte;
    logic        is_half;
    logic        misalign;
    logic        out_of_range;
    logic        req_fault;
    logic        accept;
    logic [31:0] rdata_shifted;

    // Request decode: word offset, access size, alignment and range faults
    always_comb begin
        word_off     = 30'((io_dmem_req_bits_addr - BASE_ADDR) >> 2);
        is_byte      = (io_dmem_req_bits_typ == MT_B) || (io_dmem_req_bits_typ == MT_BU);
        is_half      = (io_dmem_req_bits_typ == MT_H) || (io_dmem_req_bits_typ == MT_HU);
        if (is_byte) begin
            misalign = 1'b0;
        end else if (is_half) begin
            misalign = io_dmem_req_bits_addr[0];
        end else begin
            misalign = (io_dmem_req_bits_addr[1:0] != 2'b00);
        end
        out_of_range = (io_dmem_req_bits_addr < BASE_ADDR) ||
                       (word_off >= 30'(DEPTH_WORDS));
        req_fault    = misalign || out_of_range;
        accept       = (state_q == IDLE) && io_dmem_req_valid && !reset;
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, SRAM strobes in the accept cycle, response strobes in ACK
    always_comb begin
        state_d            = state_q;
        sram_en            = 1'b0;
        sram_we            = 1'b0;
        sram_be            = 4'b0000;
        sram_addr          = '0;
        sram_wdata         = 32'h0;
        io_dmem_resp_valid = 1'b0;
        fault_valid        = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ACK;
                    if (!req_fault) begin
                        sram_en   = 1'b1;
                        sram_we   = io_dmem_req_bits_fcn;
                        sram_addr = word_off[IDX_W-1:0];
                        if (!io_dmem_req_bits_fcn) begin
                            sram_be = 4'b1111;
                        end else if (is_byte) begin
                            sram_be    = 4'b0001 << io_dmem_req_bits_addr[1:0];
                            sram_wdata = {4{io_dmem_req_bits_data[7:0]}};
                        end else if (is_half) begin
                            sram_be    = io_dmem_req_bits_addr[1] ? 4'b1100 : 4'b0011;
                            sram_wdata = {2{io_dmem_req_bits_data[15:0]}};
                        end else begin
                            sram_be    = 4'b1111;
                            sram_wdata = io_dmem_req_bits_data;
                        end
                    end
                end
            end
            ACK: begin
                state_d            = IDLE;
                io_dmem_resp_valid = 1'b1;
                fault_valid        = fault_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture the request attributes needed to format the response
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_lo_q <= 2'b00;
            typ_q     <= 3'd0;
            fcn_q     <= 1'b0;
            fault_q   <= 1'b0;
        end else if (accept) begin
            addr_lo_q <= io_dmem_req_bits_addr[1:0];
            typ_q     <= io_dmem_req_bits_typ;
            fcn_q     <= io_dmem_req_bits_fcn;
            fault_q   <= req_fault;
        end
    end

    // Load formatting: lane shift then sign/zero extension by access type
    always_comb begin
        rdata_shifted          = sram_rdata >> {addr_lo_q, 3'b000};
        io_dmem_resp_bits_data = 32'h0;
        if ((state_q == ACK) && !fcn_q && !fault_q) begin
            case (typ_q)
                MT_B:    io_dmem_resp_bits_data = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
                MT_BU:   io_dmem_resp_bits_data = {24'h0, rdata_shifted[7:0]};
                MT_H:    io_dmem_resp_bits_data = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
                MT_HU:   io_dmem_resp_bits_data = {16'h0, rdata_shifted[15:0]};
                default: io_dmem_resp_bits_data = rdata_shifted;
            endcase
        end
    end

    // Saturating fault counter, bumped at the end of a faulted ACK
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fault_count <= 16'h0;
        end else if ((state_q == ACK) && fault_q && (fault_count != FAULT_SAT)) begin
            fault_count <= fault_count + 16'd1;
        end
    end

endmodule
